async_fifo_rd_burst_master: RTL
===============================

// Module: async_fifo_rd_burst_master
// PURPOSE
//  Read-side consumer of the async FIFO: lives entirely in the rclk domain, pops words via rinc/rempty.
//  Software-style command (start + burst_len) requests N words; words are forwarded on a valid/ready
//  stream with m_last on the final word. Pairs with the write side to close the loop in the env/DUT.
// PARAMETERS
//  DSIZE   8   FIFO data width (matches `DSIZE of the FIFO)
//  LEN_W   8   width of burst_len / word counters (max burst 2**LEN_W-1)
// PORTS
//  rclk        in   1      read-domain clock; all logic on posedge rclk
//  rrst_n      in   1      synchronous active-low reset (sampled on posedge rclk)
//  rempty      in   1      FIFO empty flag (rclk domain)
//  rdata       in   DSIZE  FIFO read data; FWFT: valid whenever !rempty, advances after rinc
//  rinc        out  1      pop strobe to FIFO
//  start       in   1      1-cycle command strobe; accepted only in IDLE
//  burst_len   in   LEN_W  words to read; sampled with accepted start
//  busy        out  1      high from accepted start until done pulse inclusive
//  done        out  1      1-cycle pulse: burst fully delivered downstream
//  m_valid     out  1      stream data valid
//  m_ready     in   1      stream sink ready
//  m_data      out  DSIZE  stream data
//  m_last      out  1      marks final word of burst (qualified by m_valid)
//  words_out   out  LEN_W  words handed off downstream in current/last burst
// BEHAVIOUR
//  Reset (rrst_n=0 at posedge): state=IDLE, rinc=0, busy=0, done=0, m_valid=0, m_last=0,
//   m_data=0, words_out=0, buffer count=0, remaining=0. Reset mid-burst abandons burst; popped words lost.
//  FSM: IDLE -start&&burst_len!=0-> BURST; IDLE -start&&burst_len==0-> DONE (no reads);
//   BURST -remaining==0 after pop-> DRAIN; DRAIN -buffer empty-> DONE; DONE -> IDLE (1 cycle).
//  start outside IDLE ignored (no queuing). Accepted start: remaining<=burst_len, words_out<=0.
//  rinc = (state==BURST) && !rempty && (remaining!=0) && (count<2); combinational from regs + rempty only
//   (no m_ready->rinc path). Each rinc: rdata written into 2-entry output buffer, remaining--.
//  Pop->output latency 1 cycle: word popped at edge N visible on m_data after edge N.
//  Output buffer: 2-entry skid FIFO, m_valid = count!=0, m_data = head. Handshake m_valid&&m_ready
//   retires head, words_out++. Simultaneous push+pop keeps count; full throughput 1 word/cycle.
//  m_valid/m_data held stable until accepted; never drop m_valid without handshake.
//  m_last = m_valid && (words_out == burst_len_q-1). Tag stored per entry is acceptable equivalent.
//  rempty=1 in BURST: rinc=0, FSM waits indefinitely (no timeout); resumes when !rempty.
//  done asserted in DONE state only; busy = state!=IDLE.
//  words_out wraps never (bounded by burst_len_q); held after done until next accepted start.
// STRUCTURE
//  Package async_fifo_rd_pkg: state enum typedef (IDLE,BURST,DRAIN,DONE), DSIZE/LEN_W defaults.
//  Sub-module: fifo_rd_skid_buf (2-entry valid/ready buffer, params DSIZE, tag bit for last).
//  Top holds FSM, remaining/words_out counters, rinc logic.
// TESTING
//  1 rrst_n=0 3 cycles mid-burst -> all outputs 0, IDLE; next start works normally.
//  2 FIFO holds 4 words A1..A4, start len=4, m_ready=1 -> rinc 4 consecutive cycles, m_data A1..A4
//    back-to-back, m_last with A4, done 1 cycle after A4 handshake, words_out=4.
//  3 len=5, FIFO empty; push 1 word every 3 rclk -> rinc only when !rempty, 5 words in order, done once.
//  4 len=6, m_ready=0 for 5 cycles -> exactly 2 pops then rinc=0, m_data held; m_ready=1 drains rest.
//  5 start len=0 -> no rinc, done pulse 2nd cycle, busy 1->0; start during BURST ignored (len unchanged).
//  6 Random m_ready/rempty, len=200 -> no loss/dup/reorder, m_last exactly on word 200, no rinc when rempty.

Source files
------------

// File: rtl/async_fifo_rd_burst_master_pkg.sv
// Shared definitions for the async FIFO read-side burst master.
//   DSIZE_DEF  default FIFO data width
//   LEN_W_DEF  default width of burst length and word counters
//   state_e    burst-control FSM states
package async_fifo_rd_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/async_fifo_rd_burst_master_if.sv
// Downstream valid/ready stream produced by the burst master.
//   m_valid  word on m_data is valid
//   m_ready  sink accepts the word this cycle
//   m_data   stream word
//   m_last   final word of the burst (qualified by m_valid)
// master: the producer (burst master); slave: the sink.
interface async_fifo_rd_burst_master_if #(
  parameter int DSIZE = async_fifo_rd_pkg::DSIZE_DEF
) ();

  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/async_fifo_rd_burst_master_skid_buf.sv
// Two-entry valid/ready output buffer with a per-entry last tag.
//   clk, rst_n  clock and synchronous active-low reset
//   in_valid    push strike; ignored while the buffer is full
//   in_data     word to store
//   in_last     last-of-burst tag stored alongside the word
//   count       occupancy (0..2), lets the producer throttle itself
//   out_valid   head entry present
//   out_data    head word (zero after reset)
//   out_last    head tag, gated by out_valid
//   out_ready   sink accepts the head this cycle
// A push and a pop in the same cycle leave the occupancy unchanged, so the
// buffer sustains one word per cycle.
module fifo_rd_skid_buf #(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_last,
  output logic [1:0]       count,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  logic [DSIZE-1:0] mem_data [2];
  logic             mem_last [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;

  assign push      = in_valid && (count != 2'd2);
  assign pop       = out_ready && (count != 2'd0);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_last  = out_valid && mem_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the two storage entries are reset as well, so out_data reads
      // zero after reset instead of whatever the flops powered up with.
      mem_data[0] <= '0;
      mem_data[1] <= '0;
      mem_last[0] <= 1'b0;
      mem_last[1] <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_last[wr_ptr] <= in_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/async_fifo_rd_burst_master.sv
// Read-side burst master for the async FIFO, entirely in the rclk domain.
//   rclk, rrst_n  read clock and synchronous active-low reset
//   rempty        FIFO empty flag
//   rdata         FIFO first-word-fall-through read data
//   rinc          pop strobe to the FIFO
//   start         one-cycle command strobe, honoured only when idle
//   burst_len     number of words to read, sampled with an accepted start
//   busy          high from accepted start through the done pulse
//   done          one-cycle pulse once the whole burst has been handed off
//   words_out     words handed downstream in the current/last burst
//   strm          downstream valid/ready stream (master side)
// Popped words pass through a two-entry skid buffer; rinc depends only on
// registered state and rempty, never on the downstream ready.
module async_fifo_rd_burst_master
  import async_fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                          rclk,
  input  logic                          rrst_n,
  input  logic                          rempty,
  input  logic [DSIZE-1:0]              rdata,
  output logic                          rinc,
  input  logic                          start,
  input  logic [LEN_W-1:0]              burst_len,
  output logic                          busy,
  output logic                          done,
  output logic [LEN_W-1:0]              words_out,
  async_fifo_rd_burst_master_if.master  strm
);

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] words_out_q;
  logic [1:0]       buf_count;
  logic             out_valid;
  logic [DSIZE-1:0] out_data;
  logic             out_last;
  logic             handshake;
  logic             accept;

  assign accept    = (state_q == IDLE) && start;
  assign rinc      = (state_q == BURST) && !rempty && (remaining_q != '0) && (buf_count < 2'd2);
  assign handshake = out_valid && strm.m_ready;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign words_out = words_out_q;

  assign strm.m_valid = out_valid;
  assign strm.m_data  = out_data;
  assign strm.m_last  = out_last;

  // The word popped while one remains is the final word of the burst.
  fifo_rd_skid_buf #(.DSIZE(DSIZE)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .in_valid  (rinc),
    .in_data   (rdata),
    .in_last   (remaining_q == LEN_W'(1)),
    .count     (buf_count),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (strm.m_ready)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (burst_len != '0) ? BURST : DONE;
      BURST:   if (rinc && (remaining_q == LEN_W'(1))) state_d = DRAIN;
      DRAIN:   if (buf_count == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (!rrst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      words_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        remaining_q <= burst_len;
        words_out_q <= '0;
      end else begin
        if (rinc)      remaining_q <= remaining_q - LEN_W'(1);
        if (handshake) words_out_q <= words_out_q + LEN_W'(1);
      end
    end
  end

endmodule
